ebpf_lsh_iter: RTL and testbench

Iterative logical left-shift unit for the eBPF core ALU, the left-direction counterpart of the combinational signed right shifter. It implements BPF_LSH for both ALU64 and ALU32 classes by applying one binary-weighted barrel stage per clock, trading latency for area. It sits beside the combinational ALU ops and is driven by the execute stage through valid/ready handshakes on both sides.

---
 rtl/ebpf_lsh_iter.sv | 111 +++++++++++
 tb/tb_ebpf_lsh_iter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/ebpf_lsh_iter.sv
// ebpf_lsh_iter: iterative logical left shift (BPF_LSH) for ALU64/ALU32.
// One binary-weighted barrel stage is applied per clock (stage k shifts by 2^k).
// Valid/ready handshakes on both the operand and result sides.
// Optional build macro EBPF_LSH_SKIP_EN: leave SHIFT as soon as no higher
// shift-amount bits remain, so latency depends on the shift amount.
module ebpf_lsh_iter #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              is_alu32,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] c
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] acc;
    logic [5:0]        sh;
    logic [2:0]        k;
    logic [2:0]        k_last;
    logic              alu32_q;
    logic              last_stage;
    logic              accept;
    logic [6:0]        shamt;

    // in_ready depends only on state; held low while reset is asserted.
    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign shamt    = 7'd1 << k;

    // Decide whether the stage applied this cycle is the final one.
    always_comb begin
`ifdef EBPF_LSH_SKIP_EN
        last_stage = (k == k_last) || ((sh >> k) >> 1) == 6'd0;
`else
        last_stage = (k == k_last);
`endif
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = SHIFT;
            SHIFT:   if (last_stage) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: latch operands, apply one shift stage per cycle, register result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            sh        <= '0;
            k         <= '0;
            k_last    <= '0;
            alu32_q   <= 1'b0;
            c         <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        acc     <= is_alu32 ? {32'h0, a[31:0]} : a;
                        sh      <= is_alu32 ? {1'b0, b[4:0]} : b[5:0];
                        k_last  <= is_alu32 ? 3'd4 : 3'd5;
                        alu32_q <= is_alu32;
                        k       <= '0;
                    end
                end
                SHIFT: begin
                    if (sh[k]) acc <= acc << shamt;
                    k <= k + 3'd1;
                end
                DONE: begin
                    // First DONE cycle registers the result; it then holds until taken.
                    if (!out_valid) begin
                        c         <= alu32_q ? {32'h0, acc[31:0]} : acc;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ebpf_lsh_iter.sv
// tb_ebpf_lsh_iter: directed-vector bench for ebpf_lsh_iter.
// Covers reset values, ALU64/ALU32 shifts, amount masking, latency,
// backpressure and an abort by reset mid-operation.
module tb_ebpf_lsh_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        is_alu32;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] c;

    int n_vec = 0;
    int n_bad = 0;

    ebpf_lsh_iter #(.DATA_W(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .is_alu32  (is_alu32),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
        end
    endtask

    // Present one operand pair, measure accept-to-out_valid latency, check result.
    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic alu32, input logic [63:0] exp_c,
                          input int lat_fixed, input int lat_skip);
        int lat;
        int exp_lat;
`ifdef EBPF_LSH_SKIP_EN
        exp_lat = lat_skip;
`else
        exp_lat = lat_fixed;
`endif
        @(negedge clk);
        a        = av;
        b        = bv;
        is_alu32 = alu32;
        in_valid = 1'b1;
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1 lat++;
            if (out_valid) break;
        end
        check({tag, " out_valid"}, 64'(out_valid), 64'd1);
        check({tag, " latency"}, 64'(lat), 64'(exp_lat));
        check({tag, " c"}, c, exp_c);
        if (out_ready) begin
            @(posedge clk);
            #1;
            check({tag, " ready after"}, 64'(in_ready), 64'd1);
            check({tag, " valid drop"}, 64'(out_valid), 64'd0);
        end
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        is_alu32  = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst c", c, 64'd0);
        @(negedge clk) rst = 1'b0;
        #1 check("idle in_ready", 64'(in_ready), 64'd1);

        // ALU64
        run_op("a64 b63", 64'h1, 64'd63, 1'b0, 64'h8000_0000_0000_0000, 7, 7);
        run_op("a64 b4", 64'h0123_4567_89AB_CDEF, 64'd4, 1'b0, 64'h1234_5678_9ABC_DEF0, 7, 4);
        run_op("a64 b64", 64'hDEAD_BEEF, 64'd64, 1'b0, 64'hDEAD_BEEF, 7, 2);
        run_op("a64 bmask", 64'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFC1, 1'b0, 64'h1_BD5B_7DDE, 7, 2);
        run_op("a64 b3", 64'h5, 64'd3, 1'b0, 64'h28, 7, 3);
        run_op("a64 b32", 64'h1, 64'd32, 1'b0, 64'h1_0000_0000, 7, 7);
        run_op("a64 b0", 64'hA5, 64'd0, 1'b0, 64'hA5, 7, 2);

        // ALU32
        run_op("a32 b1", 64'hFFFF_FFFF_8000_0001, 64'd1, 1'b1, 64'h2, 6, 2);
        run_op("a32 b33", 64'hFFFF_FFFF_8000_0001, 64'd33, 1'b1, 64'h2, 6, 2);
        run_op("a32 b31", 64'h1, 64'd31, 1'b1, 64'h8000_0000, 6, 6);
        run_op("a32 b4", 64'h0000_0000_F000_000F, 64'd4, 1'b1, 64'hF0, 6, 4);

        // Backpressure: result held, new operands ignored.
        out_ready = 1'b0;
        run_op("bp", 64'h1, 64'd8, 1'b0, 64'h100, 7, 5);
        @(negedge clk);
        in_valid = 1'b1;
        a        = 64'hFFFF;
        b        = 64'd1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp out_valid", 64'(out_valid), 64'd1);
            check("bp c", c, 64'h100);
            check("bp in_ready", 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release in_ready", 64'(in_ready), 64'd1);
        check("bp release out_valid", 64'(out_valid), 64'd0);

        // Reset during the third SHIFT cycle aborts the operation.
        @(negedge clk);
        a        = 64'hFF;
        b        = 64'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort out_valid", 64'(out_valid), 64'd0);
        check("abort c", c, 64'd0);
        check("abort in_ready", 64'(in_ready), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 if (out_valid) seen++;
        end
        check("abort no result", 64'(seen), 64'd0);
        run_op("post abort", 64'h3, 64'd2, 1'b0, 64'hC, 7, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
